// File: rtl/sfifo_stream_reader_pkg.sv
// Shared constants for the sFIFO consumer-side stream reader.
// Word width is shared with sFIFO; skid depth sizes the credit window.
package sfifo_stream_reader_pkg;

  localparam int unsigned FIFO_WIDTH     = 8;
  localparam int unsigned SKID_DEPTH     = 3;
  localparam int unsigned OCC_W          = 2;
  localparam int unsigned CRED_W         = OCC_W + 1;
  localparam int unsigned FRAME_LEN_DFLT = 4;

  // Beat counter width for a given frame length, never narrower than 1 bit.
  function automatic int unsigned beat_width(input int unsigned frame_len);
    return (frame_len > 1) ? int'($clog2(frame_len)) : 1;
  endfunction

  localparam int unsigned BEAT_W_DFLT = beat_width(FRAME_LEN_DFLT);

endpackage

// File: rtl/sfifo_stream_reader_if.sv
// FIFO read-side and downstream stream signals of the sFIFO stream reader.
// master = the reader; slave = FIFO plus stream sink.
interface sfifo_stream_reader_if
  import sfifo_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH
) ();

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rreq;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rreq, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rreq, m_data, m_valid, m_last
  );

endinterface

// File: rtl/sfifo_stream_reader_skid_buf3.sv
// Three-entry circular skid queue that absorbs the FIFO read latency.
// The head entry is always presented on dout; pop is ignored when empty.
module stream_skid_buf3
  import sfifo_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [OCC_W-1:0] head;
  logic [OCC_W-1:0] tail;
  logic             do_pop;

  function automatic logic [OCC_W-1:0] wrap_inc(input logic [OCC_W-1:0] p);
    return (p == OCC_W'(SKID_DEPTH - 1)) ? '0 : p + OCC_W'(1);
  endfunction

  assign valid  = (occ != '0);
  assign do_pop = pop & valid;
  assign dout   = mem[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= din;
        tail      <= wrap_inc(tail);
      end
      if (do_pop) head <= wrap_inc(head);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/sfifo_stream_reader.sv
// Consumer-side engine for sFIFO: credit-based reads, skid buffering,
// and valid/ready output with frame delimiting and a frame counter.
module sfifo_stream_reader
  import sfifo_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_WIDTH,
  parameter int unsigned FRAME_LEN = FRAME_LEN_DFLT,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  sfifo_stream_reader_if.master  bus,
  output logic [CNT_W-1:0]       frame_count,
  output logic                   busy
);

  localparam int unsigned       BEAT_W    = beat_width(FRAME_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  logic              in_flight;
  logic [OCC_W-1:0]  occ;
  logic              buf_valid;
  logic              pop;
  logic [BEAT_W-1:0] beat_cnt;
  logic [CRED_W-1:0] credit_used;

  stream_skid_buf3 #(.WIDTH(WIDTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (in_flight),
    .pop   (pop),
    .din   (bus.fifo_data),
    .dout  (bus.m_data),
    .valid (buf_valid),
    .occ   (occ)
  );

  // Request only from registered state so m_ready never reaches fifo_rreq.
  always_comb begin
    credit_used   = CRED_W'(occ) + CRED_W'(in_flight);
    bus.fifo_rreq = ~reset & enable & ~bus.fifo_empty
                    & (credit_used < CRED_W'(SKID_DEPTH));
    bus.m_valid   = buf_valid & ~reset;
    bus.m_last    = bus.m_valid & (beat_cnt == LAST_BEAT);
    pop           = bus.m_valid & bus.m_ready;
    busy          = ~reset & (buf_valid | in_flight);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight   <= 1'b0;
      beat_cnt    <= '0;
      frame_count <= '0;
    end else begin
      in_flight <= bus.fifo_rreq;
      if (pop) begin
        if (bus.m_last) begin
          beat_cnt    <= '0;
          frame_count <= frame_count + CNT_W'(1);
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sfifo_stream_reader.sv
// Self-checking bench for sfifo_stream_reader: FIFO model with 1-cycle read
// latency, scoreboard of written words, directed steps in one initial block.
module tb_sfifo_stream_reader;
  import sfifo_stream_reader_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned FL = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [CW-1:0] frame_count;
  logic          busy;

  sfifo_stream_reader_if #(.WIDTH(W)) bus ();

  sfifo_stream_reader #(.WIDTH(W), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] fq [$];
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  int           tb_beat = 0;
  int           tb_frames = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // sFIFO model: registered empty flag, data valid one cycle after a request.
  always @(posedge clk) begin
    if (reset) begin
      fq.delete();
      bus.fifo_empty <= 1'b1;
    end else begin
      if (bus.fifo_rreq) begin
        if (fq.size() == 0) chk("fifo_underflow", 32'(bus.fifo_rreq), 32'd0);
        else bus.fifo_data <= fq.pop_front();
      end
      if (wr_en) fq.push_back(wr_data);
      bus.fifo_empty <= (fq.size() == 0);
    end
  end

  // Stream monitor: ordering, framing, stability and occupancy.
  always @(negedge clk) begin
    if (reset) begin
      tb_beat    = 0;
      tb_frames  = 0;
      prev_stall = 1'b0;
    end else begin
      chk("occ_le3", 32'(dut.occ <= 2'd3), 32'd1);
      chk("frame_count_track", 32'(frame_count), 32'(tb_frames));
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.m_valid), 32'd1);
        chk("hold_data", 32'(bus.m_data), 32'(prev_data));
        chk("hold_last", 32'(bus.m_last), 32'(prev_last));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("stale_beat", 32'(bus.m_valid), 32'd0);
        end else begin
          chk("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
          chk("m_last", 32'(bus.m_last), 32'(tb_beat == FL - 1));
          if (tb_beat == FL - 1) begin
            tb_beat = 0;
            tb_frames++;
          end else begin
            tb_beat++;
          end
        end
      end
      prev_stall = bus.m_valid & ~bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    bus.m_ready = 1'b0;
    wr_en       = 1'b0;
    exp_q.delete();
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic write_word(input logic [W-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    exp_q.push_back(v);
    step();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      step();
      k++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    repeat (3) step();
  endtask

  initial begin
    int n;
    int k;
    int sent;
    bus.m_ready = 1'b0;

    // Streaming at full rate
    do_reset();
    for (int i = 0; i < 8; i++) write_word(W'(8'h10 + i));
    step();
    enable      = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #1;
      chk("stream_rreq", 32'(bus.fifo_rreq), 32'(i < 8));
      chk("stream_valid", 32'(bus.m_valid), 32'(i >= 2 && i < 10));
      step();
    end
    chk("stream_frames", 32'(frame_count), 32'd2);
    chk("stream_busy", 32'(busy), 32'd0);

    // Backpressure
    do_reset();
    for (int i = 0; i < 8; i++) write_word(W'(8'h10 + i));
    step();
    enable = 1'b1;
    n = 0;
    repeat (10) begin
      #1;
      if (bus.fifo_rreq) n++;
      step();
    end
    chk("bp_req_count", 32'(n), 32'd3);
    #1;
    chk("bp_rreq_off", 32'(bus.fifo_rreq), 32'd0);
    chk("bp_head", 32'(bus.m_data), 32'h10);
    bus.m_ready = 1'b1;
    drain("bp_drain");
    chk("bp_frames", 32'(frame_count), 32'd2);
    chk("bp_busy", 32'(busy), 32'd0);

    // Random ready and random FIFO writes
    do_reset();
    enable = 1'b1;
    sent = 0;
    k = 0;
    while ((sent < 1000 || exp_q.size() != 0) && k < 20000) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      if (sent < 1000 && $urandom_range(0, 1) == 1) begin
        wr_en   = 1'b1;
        wr_data = W'($urandom);
        exp_q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      step();
      k++;
    end
    wr_en       = 1'b0;
    bus.m_ready = 1'b1;
    chk("rand_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    chk("rand_frames", 32'(frame_count), 32'd250);

    // Enable dropped right after a granted request
    do_reset();
    for (int i = 0; i < 6; i++) write_word(W'(8'h40 + i));
    step();
    bus.m_ready = 1'b1;
    enable      = 1'b1;
    #1;
    chk("en_grant", 32'(bus.fifo_rreq), 32'd1);
    step();
    enable = 1'b0;
    repeat (5) begin
      #1;
      chk("en_off_rreq", 32'(bus.fifo_rreq), 32'd0);
      step();
    end
    chk("en_inflight_delivered", 32'(exp_q.size()), 32'd5);
    chk("en_off_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    drain("en_drain");
    chk("en_frames_a", 32'(frame_count), 32'd1);
    write_word(8'h50);
    write_word(8'h51);
    drain("en_drain2");
    chk("en_frames_b", 32'(frame_count), 32'd2);

    // Empty FIFO, then a single word
    do_reset();
    enable      = 1'b1;
    bus.m_ready = 1'b1;
    repeat (4) step();
    chk("empty_rreq", 32'(bus.fifo_rreq), 32'd0);
    chk("empty_valid", 32'(bus.m_valid), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    write_word(8'hA5);
    k = 0;
    while (!bus.m_valid && k < 20) begin
      step();
      k++;
    end
    chk("single_valid", 32'(bus.m_valid), 32'd1);
    chk("single_data", 32'(bus.m_data), 32'hA5);
    chk("single_last", 32'(bus.m_last), 32'd0);
    repeat (3) step();
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_frames", 32'(frame_count), 32'd0);

    // Reset with two buffered words and one read in flight
    do_reset();
    for (int i = 0; i < 5; i++) write_word(W'(8'h60 + i));
    step();
    enable = 1'b1;
    n = 0;
    k = 0;
    while (n < 3 && k < 20) begin
      #1;
      if (bus.fifo_rreq) n++;
      step();
      k++;
    end
    chk("pre_rst_occ", 32'(dut.occ), 32'd2);
    chk("pre_rst_inflight", 32'(dut.in_flight), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("in_rst_rreq", 32'(bus.fifo_rreq), 32'd0);
    chk("in_rst_valid", 32'(bus.m_valid), 32'd0);
    chk("in_rst_busy", 32'(busy), 32'd0);
    step();
    chk("post_rst_frames", 32'(frame_count), 32'd0);
    reset       = 1'b0;
    bus.m_ready = 1'b1;
    #1;
    chk("post_rst_valid", 32'(bus.m_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_rreq", 32'(bus.fifo_rreq), 32'd0);
    repeat (10) step();
    chk("post_rst_idle_valid", 32'(bus.m_valid), 32'd0);
    chk("post_rst_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfifo_stream_reader.md
Name: sfifo_stream_reader

Overview:
- Consumer-side engine for the team's synchronous FIFO (sFIFO).
- Pops words via the FIFO's request/empty interface and absorbs the FIFO's 1-cycle registered read latency.
- Presents the data downstream as a valid/ready stream, with frame delimiting (m_last) and a frame counter.
- Sits between sFIFO.Data_out and any stream sink (serializer, DMA, bus master).

Parameters:
- WIDTH, 8, data word width; must match the FIFO.
- FRAME_LEN, 4, beats per frame; m_last marks beat FRAME_LEN-1; legal 1..256.
- CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = new FIFO reads may be issued; 0 = stop issuing, but buffered and in-flight data still drain
- fifo_empty  in  1  FIFO empty flag (fifoisempty)
- fifo_data  in  WIDTH  FIFO read data (Data_out); valid 1 cycle after a granted request
- fifo_rreq  out  1  read request to FIFO (i_rreq)
- m_data  out  WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_last  out  1  last beat of frame; meaningful only while m_valid=1
- frame_count  out  CNT_W  completed frames; wraps modulo 2^CNT_W
- busy  out  1  buffered or in-flight data present

Behaviour:
- Reset: sampled on clk rising edge while reset=1. It clears occupancy, in_flight, beat counter, frame_count, m_data and m_last to 0. While reset=1, fifo_rreq is forced to 0, and m_valid and busy are 0.
- Output buffer: 3-entry circular skid queue.
  - Head entry drives m_data.
  - occ counts entries, 0..3. m_valid = (occ != 0).
  - Head and tail pointers wrap modulo 3.
- Read issue: fifo_rreq = enable & ~fifo_empty & ((occ + in_flight) < 3).
  - Registered terms only. There is no combinational path from m_ready to fifo_rreq.
  - in_flight <= fifo_rreq (a granted read).
- Capture: when in_flight=1, fifo_data is written to the tail on this edge. Latency: request in cycle N, data enters the buffer at the end of cycle N+1, and m_valid is visible in cycle N+2 at the earliest.
- Pop: on m_valid & m_ready, the head advances.
- Simultaneous capture and pop: occ is unchanged and both pointers advance.
- Throughput: sustains 1 beat/cycle with continuous FIFO data and m_ready=1.
- Overflow never occurs: the credit check guarantees occ + in_flight <= 3. A bench assertion must check occ <= 3.
- Stream rule: once m_valid=1, m_data and m_last hold stable until accepted. m_valid never drops without a handshake, except on reset.
- Frame logic:
  - beat_cnt increments on each pop; it wraps to 0 after the pop at FRAME_LEN-1.
  - m_last = m_valid & (beat_cnt == FRAME_LEN-1).
  - frame_count increments on each pop with m_last=1.
  - FRAME_LEN=1: every beat is last.
- enable deassert mid-stream:
  - No further requests are issued.
  - The in-flight word is still captured.
  - The buffer drains normally; beat_cnt is preserved, so the frame resumes when re-enabled.
- fifo_empty while a request is in flight: capture still occurs. fifo_empty gates only new requests.
- busy = (occ != 0) | in_flight.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO-side pointer has already advanced, so the system resets FIFO and reader together.

Decomposition:
- Shared package holds:
  - the FIFO word-width constant (8, shared with sFIFO);
  - the skid depth constant (3);
  - a localparam for the beat counter width, $clog2(FRAME_LEN) with minimum 1.
- One natural sub-module: stream_skid_buf3. It contains the 3-entry queue, occ and the pointers, with push/pop/data in, and data/valid/occ out.
- Request credit logic and frame counting stay in the top module.

Test Plan:
- Streaming: FIFO preloaded with 0x10..0x17, enable=1, m_ready=1 held. Required: fifo_rreq high for 8 consecutive cycles; m_data 0x10..0x17 on 8 consecutive cycles starting 2 cycles after the first request; m_last on 0x13 and 0x17; frame_count=2.
- Backpressure: 8 words loaded, m_ready=0 for 10 cycles, then 1. Required: exactly 3 requests issued, then fifo_rreq=0; m_data=0x10 held stable; after release, all 8 words arrive in order with no loss or duplication.
- Random m_ready (50%) and random FIFO writes over 1000 words. Required: the output sequence equals the input sequence; occ never exceeds 3; frame_count=250.
- enable dropped for 5 cycles in the cycle after a granted request. Required: that in-flight word is still delivered; no new fifo_rreq during the window; the frame position continues correctly after re-enable.
- Empty FIFO with enable=1. Required: fifo_rreq=0, m_valid=0, busy=0; a single write of 0xA5 produces one beat 0xA5, m_last=0 (beat 0 of 4).
- reset asserted with occ=2 and one read in flight. Required: the next cycle shows m_valid=0, busy=0, frame_count=0, fifo_rreq=0, and no stale word is delivered after reset release.
